// File: rtl/light_phase_sequencer.sv
// light_phase_sequencer
//   Converts the green-lane selection and green length coming from DayTime
//   into per-lane signal heads, cycling GREEN -> YELLOW -> ALL_RED.
//   Owns the phase countdown and raises isZero at each ALL_RED expiry so
//   DayTime advances to the next lane pair.
//
//   The FSM state is visible on the 'phase' output (0=ALL_RED, 1=GREEN,
//   2=YELLOW), and the countdown is visible on 'remaining'. Together they
//   give checkers the full control state without extra debug ports.
//
//   There is no valid/ready handshake on this block. laneReq/loadTimer are
//   treated as "always presented" and are consumed only on the clk edge
//   where tick=1 and the ALL_RED countdown expires. The isZero pulse is
//   registered, so it is high during the clk that follows that consume edge.
//   This is the cycle in which DayTime sees it and advances. If the request
//   was valid, the phase has already become GREEN in that cycle.
module light_phase_sequencer #(
    parameter int YELLOW_TIME = 3,   // yellow length in ticks (1..127)
    parameter int RED_TIME    = 2,   // all-red clearance length in ticks (1..127)
    parameter int MIN_GREEN   = 5    // floor on the requested green length (1..127)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] laneReq,
    input  logic [6:0] loadTimer,
    output logic       isZero,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic [7:0] red,
    output logic [1:0] phase,
    output logic [6:0] remaining,
    output logic       badReq
);

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phaseT;

    localparam logic [6:0] YELLOW_LEN = 7'(YELLOW_TIME);
    localparam logic [6:0] RED_LEN    = 7'(RED_TIME);
    localparam logic [6:0] MIN_LEN    = 7'(MIN_GREEN);

    // Registered state and its next-state values
    phaseT      phaseQ, phaseD;
    logic [6:0] remainingQ, remainingD;
    logic [7:0] activeQ, activeD;
    logic       badReqQ, badReqD;
    logic       isZeroQ, isZeroD;

    // Helper decodes of the inputs, used only at the ALL_RED expiry edge
    logic       laneValid;
    logic [6:0] greenLen;
    logic       expire;

    // A lane request is legal only when it selects exactly one lane pair
    assign laneValid = (laneReq == 8'h03) || (laneReq == 8'h0C) ||
                       (laneReq == 8'h30) || (laneReq == 8'hC0);

    // Short green requests are raised to the minimum green length
    assign greenLen = (loadTimer < MIN_LEN) ? MIN_LEN : loadTimer;

    // The current phase ends on the tick that sees one (or zero) ticks left
    assign expire = tick && (remainingQ <= 7'd1);

    // Next-state logic: count down on tick, and change phase on expiry
    always_comb begin
        phaseD     = phaseQ;
        remainingD = remainingQ;
        activeD    = activeQ;
        badReqD    = badReqQ;
        isZeroD    = 1'b0;

        if (tick) begin
            if (!expire) begin
                remainingD = remainingQ - 7'd1;
            end else begin
                case (phaseQ)
                    ALL_RED: begin
                        // DayTime advance strobe, pulsed on every expiry
                        isZeroD = 1'b1;
                        if (laneValid) begin
                            activeD    = laneReq;
                            phaseD     = GREEN;
                            remainingD = greenLen;
                        end else begin
                            // Never drive an illegal head pattern; hold
                            // all-red for another clearance period instead
                            activeD    = 8'h00;
                            badReqD    = 1'b1;
                            phaseD     = ALL_RED;
                            remainingD = RED_LEN;
                        end
                    end
                    GREEN: begin
                        phaseD     = YELLOW;
                        remainingD = YELLOW_LEN;
                    end
                    YELLOW: begin
                        phaseD     = ALL_RED;
                        remainingD = RED_LEN;
                        activeD    = 8'h00;
                    end
                    default: begin
                        // Encoding 3 is unused; recover to a safe all-red
                        phaseD     = ALL_RED;
                        remainingD = RED_LEN;
                        activeD    = 8'h00;
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset that has priority over tick
    always_ff @(posedge clk) begin
        if (rst) begin
            phaseQ     <= ALL_RED;
            remainingQ <= RED_LEN;
            activeQ    <= 8'h00;
            badReqQ    <= 1'b0;
            isZeroQ    <= 1'b0;
        end else begin
            phaseQ     <= phaseD;
            remainingQ <= remainingD;
            activeQ    <= activeD;
            badReqQ    <= badReqD;
            isZeroQ    <= isZeroD;
        end
    end

    // Head decode from registers only. Green and yellow are never both
    // active, and red covers every lane that is neither green nor yellow.
    assign green     = (phaseQ == GREEN)  ? activeQ : 8'h00;
    assign yellow    = (phaseQ == YELLOW) ? activeQ : 8'h00;
    assign red       = ~(green | yellow);
    assign phase     = phaseQ;
    assign remaining = remainingQ;
    assign badReq    = badReqQ;
    assign isZero    = isZeroQ;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// tb_light_phase_sequencer
//   Directed, table-driven bench for light_phase_sequencer with the
//   default parameters YELLOW_TIME=3, RED_TIME=2, MIN_GREEN=5.
//   Each table row applies one clock with the given rst/tick/laneReq/
//   loadTimer values, then checks every output #1 after that edge.
//   A hand-written sequence follows, which holds tick high continuously.
module tb_light_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] laneReq;
    logic [6:0] loadTimer;
    logic       isZero;
    logic [7:0] green;
    logic [7:0] yellow;
    logic [7:0] red;
    logic [1:0] phase;
    logic [6:0] remaining;
    logic       badReq;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] P_AR = 2'd0;
    localparam logic [1:0] P_G  = 2'd1;
    localparam logic [1:0] P_Y  = 2'd2;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [7:0] laneReq;
        logic [6:0] loadTimer;
        logic [1:0] expPhase;
        logic [6:0] expRemaining;
        logic [7:0] expGreen;
        logic [7:0] expYellow;
        logic       expIsZero;
        logic       expBadReq;
    } vecT;

    vecT        vecs[512];
    int         numVecs = 0;
    logic [7:0] fillReq;
    logic [6:0] fillLoad;
    logic       expQ[$];

    light_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .laneReq   (laneReq),
        .loadTimer (loadTimer),
        .isZero    (isZero),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .phase     (phase),
        .remaining (remaining),
        .badReq    (badReq)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one table row. The row uses the current fillReq/fillLoad inputs.
    task automatic addVec(input logic r, input logic t, input logic [1:0] ph,
                          input logic [6:0] rem, input logic [7:0] g,
                          input logic [7:0] y, input logic iz, input logic bad);
        vecs[numVecs].rst          = r;
        vecs[numVecs].tick         = t;
        vecs[numVecs].laneReq      = fillReq;
        vecs[numVecs].loadTimer    = fillLoad;
        vecs[numVecs].expPhase     = ph;
        vecs[numVecs].expRemaining = rem;
        vecs[numVecs].expGreen     = g;
        vecs[numVecs].expYellow    = y;
        vecs[numVecs].expIsZero    = iz;
        vecs[numVecs].expBadReq    = bad;
        numVecs++;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Driver: apply inputs for one clock, then settle #1 past the edge
    task automatic applyCycle(input logic r, input logic t,
                              input logic [7:0] req, input logic [6:0] load);
        rst       = r;
        tick      = t;
        laneReq   = req;
        loadTimer = load;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRow(input int idx);
        check("phase",     idx, {6'd0, phase},     {6'd0, vecs[idx].expPhase});
        check("remaining", idx, {1'b0, remaining}, {1'b0, vecs[idx].expRemaining});
        check("green",     idx, green,             vecs[idx].expGreen);
        check("yellow",    idx, yellow,            vecs[idx].expYellow);
        check("red",       idx, red,
              ~(vecs[idx].expGreen | vecs[idx].expYellow));
        check("isZero",    idx, {7'd0, isZero},    {7'd0, vecs[idx].expIsZero});
        check("badReq",    idx, {7'd0, badReq},    {7'd0, vecs[idx].expBadReq});
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; laneReq = 8'h00; loadTimer = 7'd0;

        // ---- build the table ----
        // Reset for 2 clks, then one idle clk with no tick
        fillReq = 8'h03; fillLoad = 7'd10;
        addVec(1, 0, P_AR, 2, 8'h00, 8'h00, 0, 0);
        addVec(1, 0, P_AR, 2, 8'h00, 8'h00, 0, 0);
        addVec(0, 0, P_AR, 2, 8'h00, 8'h00, 0, 0);
        // Green 03 for 10 ticks; isZero is pulsed on the 2nd tick
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 0);
        addVec(0, 1, P_G, 10, 8'h03, 8'h00, 1, 0);
        // Inputs changed mid-green are ignored
        fillReq = 8'h30; fillLoad = 7'd20;
        addVec(0, 0, P_G, 10, 8'h03, 8'h00, 0, 0);
        for (int i = 9; i >= 1; i--) addVec(0, 1, P_G, 7'(i), 8'h03, 8'h00, 0, 0);
        addVec(0, 1, P_Y, 3, 8'h00, 8'h03, 0, 0);
        addVec(0, 1, P_Y, 2, 8'h00, 8'h03, 0, 0);
        addVec(0, 1, P_Y, 1, 8'h00, 8'h03, 0, 0);
        addVec(0, 1, P_AR, 2, 8'h00, 8'h00, 0, 0);
        // Multi-pair request at expiry: badReq set, stays all-red
        fillReq = 8'h0F; fillLoad = 7'd9;
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 0);
        addVec(0, 1, P_AR, 2, 8'h00, 8'h00, 1, 1);
        addVec(0, 0, P_AR, 2, 8'h00, 8'h00, 0, 1);
        // Next expiry with 30: green 30 for 6 ticks, badReq stays set
        fillReq = 8'h30; fillLoad = 7'd6;
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 1);
        addVec(0, 1, P_G, 6, 8'h30, 8'h00, 1, 1);
        for (int i = 5; i >= 1; i--) addVec(0, 1, P_G, 7'(i), 8'h30, 8'h00, 0, 1);
        addVec(0, 1, P_Y, 3, 8'h00, 8'h30, 0, 1);
        addVec(0, 1, P_Y, 2, 8'h00, 8'h30, 0, 1);
        addVec(0, 1, P_Y, 1, 8'h00, 8'h30, 0, 1);
        addVec(0, 1, P_AR, 2, 8'h00, 8'h00, 0, 1);
        // loadTimer=0 with C0: green lasts MIN_GREEN=5 ticks
        fillReq = 8'hC0; fillLoad = 7'd0;
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 1);
        addVec(0, 1, P_G, 5, 8'hC0, 8'h00, 1, 1);
        for (int i = 4; i >= 1; i--) addVec(0, 1, P_G, 7'(i), 8'hC0, 8'h00, 0, 1);
        addVec(0, 1, P_Y, 3, 8'h00, 8'hC0, 0, 1);
        addVec(0, 1, P_Y, 2, 8'h00, 8'hC0, 0, 1);
        // rst together with tick mid-yellow: rst wins, badReq cleared
        addVec(1, 1, P_AR, 2, 8'h00, 8'h00, 0, 0);
        // Zero request is invalid
        fillReq = 8'h00; fillLoad = 7'd8;
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 0);
        addVec(0, 1, P_AR, 2, 8'h00, 8'h00, 1, 1);
        // loadTimer=127 with 0C: 127 ticks of green, no overflow
        fillReq = 8'h0C; fillLoad = 7'd127;
        addVec(0, 1, P_AR, 1, 8'h00, 8'h00, 0, 1);
        addVec(0, 1, P_G, 127, 8'h0C, 8'h00, 1, 1);
        for (int i = 126; i >= 1; i--) addVec(0, 1, P_G, 7'(i), 8'h0C, 8'h00, 0, 1);
        addVec(0, 1, P_Y, 3, 8'h00, 8'h0C, 0, 1);
        addVec(1, 0, P_AR, 2, 8'h00, 8'h00, 0, 0);

        // ---- apply the table ----
        for (int v = 0; v < numVecs; v++) begin
            applyCycle(vecs[v].rst, vecs[v].tick, vecs[v].laneReq, vecs[v].loadTimer);
            checkRow(v);
        end

        // ---- hand sequence: tick held high, invalid request held ----
        // From reset (remaining=2), every clk counts as a tick. Each second
        // clk is an all-red expiry, so isZero alternates 0,1,0,1,...
        for (int i = 0; i < 8; i++) expQ.push_back(i[0]);
        while (expQ.size() > 0) begin
            logic e;
            e = expQ.pop_front();
            applyCycle(1'b0, 1'b1, 8'hFF, 7'd10);
            check("heldTickIsZero", 1000, {7'd0, isZero}, {7'd0, e});
            check("heldTickPhase",  1000, {6'd0, phase},  {6'd0, P_AR});
            check("heldTickRed",    1000, red,            8'hFF);
        end
        check("heldTickBadReq", 1001, {7'd0, badReq}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
